ysyx_23060221_ifu_fetch: RTL and testbench

Instruction fetch stage directly downstream of the write-back/PC stage. It accepts the next PC over a valid/ready handshake (WBU_valid / IFU_ready) and issues a single-beat AXI4-Lite read for the instruction word. It presents the fetched instruction and its PC to the decode stage over IFU_valid / IDU_ready. It handles exactly one outstanding fetch; there is no prefetch and no buffering beyond one instruction.

---
 rtl/ysyx_23060221_ifu_fetch_if.sv | 24 ++
 rtl/ysyx_23060221_ifu_fetch.sv | 131 +++++++++++++
 tb/tb_ysyx_23060221_ifu_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060221_ifu_fetch_if.sv
// AXI4-Lite read-channel bundle between the instruction fetch stage (master)
// and the instruction memory / bus fabric (slave).
interface ysyx_23060221_ifu_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060221_ifu_fetch.sv
// Single-outstanding instruction fetch: PC in, one AXI4-Lite read, instruction out.
// Optional macro IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_23060221_ifu_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef IFU_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         pc,
  input  logic                      WBU_valid,
  output logic                      IFU_ready,
  ysyx_23060221_ifu_fetch_if.master bus,
  output logic [DATA_W-1:0]         inst,
  output logic [ADDR_W-1:0]         inst_pc,
  output logic                      fetch_err,
  output logic                      IFU_valid,
  input  logic                      IDU_ready,
  output logic [1:0]                dbg_state
`ifdef IFU_PERF_EN
  , output logic [PERF_W-1:0]       perf_fetch_cnt,
  output logic [PERF_W-1:0]         perf_stall_cnt
`endif
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both 1; valid is held with its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2, OUT = 2'd3} state_t;

  state_t            state, state_n;
  logic              ifu_ready_n, arvalid_n, rready_n, ifu_valid_n, fetch_err_n;
  logic [DATA_W-1:0] inst_n;
  logic [ADDR_W-1:0] inst_pc_n, araddr_n;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      IFU_ready   <= 1'b1;
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
      IFU_valid   <= 1'b0;
      fetch_err   <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      bus.araddr  <= '0;
    end else begin
      state       <= state_n;
      IFU_ready   <= ifu_ready_n;
      bus.arvalid <= arvalid_n;
      bus.rready  <= rready_n;
      IFU_valid   <= ifu_valid_n;
      fetch_err   <= fetch_err_n;
      inst        <= inst_n;
      inst_pc     <= inst_pc_n;
      bus.araddr  <= araddr_n;
    end
  end

  always_comb begin
    state_n     = state;
    ifu_ready_n = IFU_ready;
    arvalid_n   = bus.arvalid;
    rready_n    = bus.rready;
    ifu_valid_n = IFU_valid;
    fetch_err_n = fetch_err;
    inst_n      = inst;
    inst_pc_n   = inst_pc;
    araddr_n    = bus.araddr;
    case (state)
      IDLE: begin
        if (WBU_valid && IFU_ready) begin
          inst_pc_n   = pc;
          araddr_n    = pc;
          ifu_ready_n = 1'b0;
          // A misaligned PC never reaches the bus; it is reported straight away.
          if (pc[1:0] != 2'b00) begin
            state_n     = OUT;
            fetch_err_n = 1'b1;
            inst_n      = '0;
            ifu_valid_n = 1'b1;
          end else begin
            arvalid_n = 1'b1;
            state_n   = AR;
          end
        end
      end
      AR: begin
        if (bus.arvalid && bus.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = R;
        end
      end
      R: begin
        if (bus.rvalid && bus.rready) begin
          inst_n      = bus.rdata;
          fetch_err_n = (bus.rresp != 2'b00);
          rready_n    = 1'b0;
          ifu_valid_n = 1'b1;
          state_n     = OUT;
        end
      end
      OUT: begin
        if (IFU_valid && IDU_ready) begin
          ifu_valid_n = 1'b0;
          fetch_err_n = 1'b0;
          ifu_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (IFU_valid && IDU_ready) perf_fetch_cnt <= perf_fetch_cnt + PERF_W'(1);
      if (state == AR || state == R) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060221_ifu_fetch.sv
// Directed bench for ysyx_23060221_ifu_fetch: aligned fetch, AR stall, bus
// error, misaligned pc, decode backpressure and reset in the middle of a read.
module tb_ysyx_23060221_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        WBU_valid;
  logic        IFU_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        IFU_valid;
  logic        IDU_ready;
  logic [1:0]  dbg_state;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int passes = 0;
  int total  = 0;

  ysyx_23060221_ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_23060221_ifu_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .WBU_valid (WBU_valid),
    .IFU_ready (IFU_ready),
    .bus       (bus),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .fetch_err (fetch_err),
    .IFU_valid (IFU_valid),
    .IDU_ready (IDU_ready),
    .dbg_state (dbg_state)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst         = 1'b1;
    pc          = '0;
    WBU_valid   = 1'b0;
    IDU_ready   = 1'b0;
    bus.arready = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rvalid  = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_ifu_ready", IFU_ready, 1);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_ifu_valid", IFU_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    chk("idle_ifu_ready", IFU_ready, 1);

    // aligned fetch, bus always ready: accept cycle, AR, R, then OUT in the third cycle after
    pc = 32'h8000_0000; WBU_valid = 1'b1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0413; bus.rresp = 2'b00;
    tick();
    WBU_valid = 1'b0; pc = 32'h1111_1110;
    chk("f1_arvalid", bus.arvalid, 1);
    chk("f1_araddr", bus.araddr, 32'h8000_0000);
    chk("f1_rready_in_ar", bus.rready, 0);
    chk("f1_ifu_ready", IFU_ready, 0);
    chk("f1_valid_c1", IFU_valid, 0);
    tick();
    chk("f1_rready", bus.rready, 1);
    chk("f1_arvalid_off", bus.arvalid, 0);
    chk("f1_valid_c2", IFU_valid, 0);
    tick();
    chk("f1_valid_c3", IFU_valid, 1);
    chk("f1_inst", inst, 32'h0000_0413);
    chk("f1_inst_pc", inst_pc, 32'h8000_0000);
    chk("f1_fetch_err", fetch_err, 0);
    chk("f1_rready_off", bus.rready, 0);
    bus.rvalid = 1'b0; bus.rdata = 32'hFFFF_FFFF;

    // decode backpressure for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", IFU_valid, 1);
      chk("bp_inst", inst, 32'h0000_0413);
      chk("bp_inst_pc", inst_pc, 32'h8000_0000);
      chk("bp_ifu_ready", IFU_ready, 0);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("bp_done_valid", IFU_valid, 0);
    chk("bp_done_ready", IFU_ready, 1);

    // AR stalled 5 cycles, then a bus-error read response
    pc = 32'h8000_0004; WBU_valid = 1'b1; bus.arready = 1'b0;
    tick();
    WBU_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ars_arvalid", bus.arvalid, 1);
      chk("ars_araddr", bus.araddr, 32'h8000_0004);
      chk("ars_rready", bus.rready, 0);
      tick();
    end
    chk("ars_still_ar", dbg_state, 1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("ars_rready_on", bus.rready, 1);
    chk("ars_arvalid_off", bus.arvalid, 0);
    tick();
    chk("r_wait_rready", bus.rready, 1);
    chk("r_wait_valid", IFU_valid, 0);
    bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0; bus.rresp = 2'b00;
    chk("err_valid", IFU_valid, 1);
    chk("err_fetch_err", fetch_err, 1);
    chk("err_inst", inst, 32'hDEAD_BEEF);
    chk("err_inst_pc", inst_pc, 32'h8000_0004);
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("err_cleared", fetch_err, 0);
    chk("err_ready", IFU_ready, 1);

    // misaligned pc: no bus access, error reported on the next cycle
    pc = 32'h8000_0002; WBU_valid = 1'b1; bus.arready = 1'b1;
    tick();
    WBU_valid = 1'b0;
    chk("mis_valid", IFU_valid, 1);
    chk("mis_fetch_err", fetch_err, 1);
    chk("mis_inst", inst, 0);
    chk("mis_inst_pc", inst_pc, 32'h8000_0002);
    chk("mis_arvalid", bus.arvalid, 0);
    chk("mis_ifu_ready", IFU_ready, 0);
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("mis_arvalid_after", bus.arvalid, 0);
    chk("mis_back_idle", IFU_ready, 1);

`ifdef IFU_PERF_EN
    // three fetches; stall cycles: 2 (first) + 6 AR + 2 R (second)
    chk("perf_fetch", perf_fetch_cnt, 3);
    chk("perf_stall", perf_stall_cnt, 10);
`endif

    // reset while in R with a beat on the same edge
    pc = 32'h8000_0008; WBU_valid = 1'b1; bus.arready = 1'b1;
    tick();
    WBU_valid = 1'b0;
    tick();
    chk("rr_in_r", bus.rready, 1);
    rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
    tick();
    rst = 1'b0; bus.rvalid = 1'b0; bus.arready = 1'b0;
    chk("rr_state", dbg_state, 0);
    chk("rr_rready", bus.rready, 0);
    chk("rr_valid", IFU_valid, 0);
    chk("rr_ready", IFU_ready, 1);
    chk("rr_inst", inst, 0);
    chk("rr_inst_pc", inst_pc, 0);
`ifdef IFU_PERF_EN
    chk("rr_perf_fetch", perf_fetch_cnt, 0);
    chk("rr_perf_stall", perf_stall_cnt, 0);
`endif
    tick();
    chk("rr_dropped", IFU_valid, 0);
    chk("rr_no_ar", bus.arvalid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
